mem_bus_responder: RTL and testbench

Memory-side end of the shared 8-bit tri-state data bus used by the 8-bit RISC core. It decodes the core's `sel`/`rd`/`wr`/`data_e` strobes and serves a 32-byte register-file memory. It drives `bidr` on reads, captures `bidr` on writes and enforces a one-cycle bus turnaround so it never drives against the core. An optional program-loader port with a valid/ready handshake fills memory while the core is idle.

---
 rtl/mem_bus_responder_pkg.sv | 42 ++++
 rtl/mem_bus_responder_if.sv | 36 +++
 rtl/mem_bus_responder_tri_driver.sv | 17 +
 rtl/mem_bus_responder.sv | 101 ++++++++++
 tb/tb_mem_bus_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared types and constants for the memory-side bus responder.
package mem_bus_responder_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned MEM_DEPTH  = 32'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_DRIVE = 2'd1,
        TURN     = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        OP_NONE     = 2'd0,
        OP_READ     = 2'd1,
        OP_WRITE    = 2'd2,
        OP_CONFLICT = 2'd3
    } bus_op_e;

    // {rd, wr} strobe patterns, shared with the core-side controller
    localparam logic [1:0] STRB_RD = 2'b10;
    localparam logic [1:0] STRB_WR = 2'b01;
    localparam logic [1:0] STRB_RW = 2'b11;

    // Classify one sampled set of core strobes
    function automatic bus_op_e decode_op(input logic sel, input logic rd,
                                          input logic wr, input logic data_e);
        bus_op_e op;
        op = OP_NONE;
        if (sel) begin
            case ({rd, wr})
                STRB_RD: op = OP_READ;
                STRB_WR: op = data_e ? OP_WRITE : OP_NONE;
                STRB_RW: op = OP_CONFLICT;
                default: op = OP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Core strobes, status and optional loader handshake (MEM_BUS_LOADER_EN).
interface mem_bus_responder_if;
    import mem_bus_responder_pkg::*;

    logic                  sel;
    logic                  rd;
    logic                  wr;
    logic                  data_e;
    logic [ADDR_WIDTH-1:0] address;
    logic                  drv_en;
    logic                  bus_err;
`ifdef MEM_BUS_LOADER_EN
    logic                  ld_valid;
    logic                  ld_ready;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;

    modport master (
        output sel, rd, wr, data_e, address, ld_valid, ld_addr, ld_data,
        input  drv_en, bus_err, ld_ready
    );
    modport slave (
        input  sel, rd, wr, data_e, address, ld_valid, ld_addr, ld_data,
        output drv_en, bus_err, ld_ready
    );
`else
    modport master (
        output sel, rd, wr, data_e, address,
        input  drv_en, bus_err
    );
    modport slave (
        input  sel, rd, wr, data_e, address,
        output drv_en, bus_err
    );
`endif
endinterface

// File: rtl/mem_bus_responder_tri_driver.sv
// Parameterised tri-state pad driver with read-back of the pad value.
module tri_driver #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    inout  wire  [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] q
);

    // Drive the pad only when enabled, otherwise release it
    assign pad = en ? d : {WIDTH{1'bz}};

    // Whatever is on the pad, whoever drives it
    assign q = pad;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder on the shared 8-bit tri-state bus: 32x8 memory,
// read drive with one-cycle turnaround, sticky protocol error flag.
// Optional program loader port enabled by defining MEM_BUS_LOADER_EN.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mem_bus_responder_if.slave    bus,
    inout  wire  [DATA_WIDTH-1:0] bidr
);

    mem_state_e            state;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] bus_q_c;
    bus_op_e               op_c;
    logic                  core_we_c;

    assign op_c      = decode_op(bus.sel, bus.rd, bus.wr, bus.data_e);
    // Core writes land only when the bus is fully turned around
    assign core_we_c = (state == IDLE) && (op_c == OP_WRITE);

`ifdef MEM_BUS_LOADER_EN
    logic ld_we_c;

    // Loader gets the memory only while the core leaves the bus untouched
    assign bus.ld_ready = !rst && (state == IDLE) && !bus.sel;
    assign ld_we_c      = bus.ld_valid && bus.ld_ready;
`endif

    // Pad driver: releases bidr asynchronously when drv_en resets
    tri_driver #(
        .WIDTH (DATA_WIDTH)
    ) u_tri_driver (
        .en  (bus.drv_en),
        .d   (rd_q),
        .pad (bidr),
        .q   (bus_q_c)
    );

    // Storage: core write port, optional loader write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (core_we_c) begin
            mem[bus.address] <= bus_q_c;
`ifdef MEM_BUS_LOADER_EN
        end else if (ld_we_c) begin
            mem[bus.ld_addr] <= bus.ld_data;
`endif
        end
    end

    // Bus FSM: read drive, turnaround, error detection; registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_q        <= '0;
            bus.drv_en  <= 1'b0;
            bus.bus_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_c == OP_READ) begin
                        rd_q       <= mem[bus.address];
                        bus.drv_en <= 1'b1;
                        state      <= RD_DRIVE;
                    end else if (op_c == OP_CONFLICT) begin
                        bus.bus_err <= 1'b1;
                    end
                end
                RD_DRIVE: begin
                    if ((op_c == OP_WRITE) || (op_c == OP_CONFLICT)) begin
                        bus.bus_err <= 1'b1;
                    end
                    if (op_c == OP_READ) begin
                        rd_q <= mem[bus.address];
                    end else if (op_c != OP_CONFLICT) begin
                        // sel&rd dropped: release the bus for one cycle
                        bus.drv_en <= 1'b0;
                        state      <= TURN;
                    end
                end
                TURN: begin
                    if ((op_c == OP_WRITE) || (op_c == OP_CONFLICT)) begin
                        bus.bus_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    bus.drv_en <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: vector table plus hand-written corner cases,
// read data checked through an expected-value queue.
module tb_mem_bus_responder;
    import mem_bus_responder_pkg::*;

    typedef enum logic [1:0] {V_RD, V_WR, V_WR_NODE} vop_e;
    typedef struct {
        vop_e       op;
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       tb_oe;
    logic [7:0] tb_d;
    wire  [7:0] bidr;

    int n_cmp;
    int n_fail;
    logic [7:0] sb_q [$];
    vec_t vecs [12];

    mem_bus_responder_if bus ();

    mem_bus_responder dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .bidr (bidr)
    );

    assign bidr = tb_oe ? tb_d : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.sel = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.data_e = 1'b0;
        tb_oe = 1'b0;
    endtask

    task automatic sb_check(input string name);
        logic [7:0] e;
        if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: got no expected entry, required one queued", name);
        end else begin
            e = sb_q.pop_front();
            check(name, 32'(bidr), 32'(e));
        end
    endtask

    task automatic do_reset();
        bus_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d, input logic de);
        bus.sel = 1'b1; bus.wr = 1'b1; bus.data_e = de; bus.address = a;
        tb_oe = de; tb_d = d;
        tick();
        bus_idle();
    endtask

    task automatic do_read(input logic [4:0] a, input logic [7:0] exp);
        bus.sel = 1'b1; bus.rd = 1'b1; bus.address = a;
        sb_q.push_back(exp);
        tick();
        check("rd_drv_en", 32'(bus.drv_en), 32'd1);
        sb_check("rd_data");
        bus.sel = 1'b0; bus.rd = 1'b0;
        tick();
        check("rd_release", 32'(bus.drv_en), 32'd0);
        tick();
    endtask

    initial begin
        int n_acc;
        logic rdy;

        n_cmp = 0; n_fail = 0;
        tb_d = '0; bus.address = '0;
        bus_idle();
`ifdef MEM_BUS_LOADER_EN
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
`endif
        vecs[0]  = '{V_WR,      5'd3,  8'hA5, 8'h00};
        vecs[1]  = '{V_RD,      5'd3,  8'h00, 8'hA5};
        vecs[2]  = '{V_RD,      5'd5,  8'h00, 8'h00};
        vecs[3]  = '{V_WR,      5'd0,  8'hFF, 8'h00};
        vecs[4]  = '{V_WR,      5'd31, 8'h3C, 8'h00};
        vecs[5]  = '{V_RD,      5'd0,  8'h00, 8'hFF};
        vecs[6]  = '{V_RD,      5'd31, 8'h00, 8'h3C};
        vecs[7]  = '{V_WR_NODE, 5'd1,  8'h77, 8'h00};
        vecs[8]  = '{V_RD,      5'd1,  8'h00, 8'h00};
        vecs[9]  = '{V_WR,      5'd1,  8'h5A, 8'h00};
        vecs[10] = '{V_RD,      5'd1,  8'h00, 8'h5A};
        vecs[11] = '{V_RD,      5'd3,  8'h00, 8'hA5};

        // Reset state
        rst = 1'b1;
        tick();
        check("rst_drv_en", 32'(bus.drv_en), 32'd0);
        check("rst_bus_err", 32'(bus.bus_err), 32'd0);
`ifdef MEM_BUS_LOADER_EN
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Vector table
        foreach (vecs[k]) begin
            case (vecs[k].op)
                V_RD:      do_read(vecs[k].addr, vecs[k].exp);
                V_WR:      do_write(vecs[k].addr, vecs[k].data, 1'b1);
                default:   do_write(vecs[k].addr, vecs[k].data, 1'b0);
            endcase
        end
        check("table_bus_err", 32'(bus.bus_err), 32'd0);

        // Back-to-back reads, address changes each cycle
        bus.sel = 1'b1; bus.rd = 1'b1; bus.address = 5'd0;
        sb_q.push_back(8'hFF);
        tick();
        sb_check("b2b_0");
        bus.address = 5'd31; sb_q.push_back(8'h3C);
        tick();
        sb_check("b2b_1");
        bus.address = 5'd1; sb_q.push_back(8'h5A);
        tick();
        sb_check("b2b_2");
        check("b2b_drv_en", 32'(bus.drv_en), 32'd1);
        bus_idle();
        tick();
        tick();

        // Earliest legal write after release (edge M+2)
        bus.sel = 1'b1; bus.rd = 1'b1; bus.address = 5'd5;
        tick();
        bus_idle();
        tick();
        tick();
        do_write(5'd5, 8'hC3, 1'b1);
        do_read(5'd5, 8'hC3);
        check("m2_bus_err", 32'(bus.bus_err), 32'd0);

        // Write during TURN is rejected and flags a sticky error
        bus.sel = 1'b1; bus.rd = 1'b1; bus.address = 5'd3;
        tick();
        bus_idle();
        tick();
        do_write(5'd3, 8'h11, 1'b1);
        check("turn_wr_err", 32'(bus.bus_err), 32'd1);
        tick();
        do_read(5'd3, 8'hA5);
        tick();
        tick();
        check("err_sticky", 32'(bus.bus_err), 32'd1);
        do_reset();
        check("err_cleared", 32'(bus.bus_err), 32'd0);

        // Read+write together: no access, error set
        bus.sel = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.address = 5'd7;
        tick();
        check("rw_drv_en", 32'(bus.drv_en), 32'd0);
        check("rw_bus_err", 32'(bus.bus_err), 32'd1);
        bus_idle();
        tick();
        do_reset();

        // Asynchronous reset while driving
        do_write(5'd9, 8'h99, 1'b1);
        bus.sel = 1'b1; bus.rd = 1'b1; bus.address = 5'd9;
        tick();
        check("ar_drv_before", 32'(bus.drv_en), 32'd1);
        check("ar_data_before", 32'(bidr), 32'h99);
        #3 rst = 1'b1;
        #1 check("ar_drv_async", 32'(bus.drv_en), 32'd0);
        bus_idle();
        tick();
        rst = 1'b0;
        tick();
        do_read(5'd9, 8'h00);

`ifdef MEM_BUS_LOADER_EN
        // Loader stream with a core read inserted mid-stream
        do_reset();
        n_acc = 0;
        for (int cyc = 0; cyc < 200 && n_acc < 16; cyc++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 5'(n_acc);
            bus.ld_data  = 8'(16 + n_acc);
            bus.sel      = (cyc == 4);
            bus.rd       = (cyc == 4);
            bus.address  = 5'd20;
            if (cyc == 4) sb_q.push_back(8'h00);
            #1;
            rdy = bus.ld_ready;
            if (cyc == 4) check("ld_ready_sel", 32'(rdy), 32'd0);
            if (cyc == 5 || cyc == 6) check("ld_ready_busy", 32'(rdy), 32'd0);
            @(posedge clk);
            #1;
            if (rdy) n_acc++;
            if (cyc == 4) sb_check("ld_core_rd");
        end
        bus.ld_valid = 1'b0;
        bus_idle();
        check("ld_count", 32'(n_acc), 32'd16);
        tick();
        tick();
        for (int a = 0; a < 16; a++) begin
            do_read(5'(a), 8'(16 + a));
        end
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
